// File: rtl/uart_tx_pkg.sv
// Shared types and constants for the UART transmit framer.
package uart_tx_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } tx_state_e;

  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

endpackage

// File: rtl/uart_tx_framer_if.sv
// Payload/configuration handshake between a frame producer and the UART framer.
interface uart_tx_framer_if #(
  parameter int DATA_WIDTH = 8
);
  logic [DATA_WIDTH-1:0] P_DATA;
  logic                  DATA_VALID;
  logic                  DATA_ACK;
  logic                  PAR_EN;
  logic                  PAR_TYP;
  logic                  STOP_2;

  modport master (output P_DATA, DATA_VALID, PAR_EN, PAR_TYP, STOP_2, input DATA_ACK);
  modport slave  (input P_DATA, DATA_VALID, PAR_EN, PAR_TYP, STOP_2, output DATA_ACK);
endinterface

// File: rtl/uart_parity_calc.sv
// Parity of the latched payload: plain XOR for even parity, inverted for odd.
module uart_parity_calc
  import uart_tx_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic [DATA_WIDTH-1:0] data,
  input  logic                  par_typ,
  output logic                  par_bit
);

  assign par_bit = (par_typ == PAR_EVEN) ? ^data : ~(^data);

endmodule

// File: rtl/uart_tx_framer.sv
// UART transmit framer: start bit, LSB-first payload, optional parity, one or two
// stop bits, all paced by the TICK bit-boundary enable.
module uart_tx_framer
  import uart_tx_pkg::*;
#(
  parameter int   DATA_WIDTH = 8,
  parameter logic IDLE_LEVEL = 1'b1
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              TICK,
  uart_tx_framer_if.slave   bus,
  output logic              TX_OUT,
  output logic              BUSY
);

  localparam int CNT_W = $clog2(DATA_WIDTH);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

  tx_state_e             state;
  logic [DATA_WIDTH-1:0] data_q;
  logic [CNT_W-1:0]      bit_cnt;
  logic [CNT_W-1:0]      bit_nxt;
  logic                  par_en_q;
  logic                  par_typ_q;
  logic                  stop2_q;
  logic                  stop_second;
  logic                  ack_q;
  logic                  par_bit;
  logic                  accept;

  uart_parity_calc #(.DATA_WIDTH(DATA_WIDTH)) u_parity (
    .data    (data_q),
    .par_typ (par_typ_q),
    .par_bit (par_bit)
  );

  // A new frame is taken from idle or on the tick that closes the last stop bit,
  // so a held DATA_VALID streams frames with no idle gap.
  always_comb begin
    accept  = 1'b0;
    bit_nxt = bit_cnt + 1'b1;
    if (TICK && bus.DATA_VALID) begin
      accept = (state == ST_IDLE) ||
               ((state == ST_STOP) && (!stop2_q || stop_second));
    end
  end

  assign bus.DATA_ACK = ack_q;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state       <= ST_IDLE;
      TX_OUT      <= IDLE_LEVEL;
      BUSY        <= 1'b0;
      ack_q       <= 1'b0;
      bit_cnt     <= '0;
      data_q      <= '0;
      par_en_q    <= 1'b0;
      par_typ_q   <= 1'b0;
      stop2_q     <= 1'b0;
      stop_second <= 1'b0;
    end else begin
      // NOTE: default-low assignment ahead of the branches makes DATA_ACK a
      // one-cycle pulse; the later non-blocking write on acceptance wins.
      ack_q <= 1'b0;
      if (accept) begin
        data_q      <= bus.P_DATA;
        par_en_q    <= bus.PAR_EN;
        par_typ_q   <= bus.PAR_TYP;
        stop2_q     <= bus.STOP_2;
        stop_second <= 1'b0;
        state       <= ST_START;
        TX_OUT      <= ~IDLE_LEVEL;
        BUSY        <= 1'b1;
        ack_q       <= 1'b1;
      end else if (TICK) begin
        unique case (state)
          ST_IDLE: state <= ST_IDLE;
          ST_START: begin
            state   <= ST_DATA;
            bit_cnt <= '0;
            TX_OUT  <= data_q[0];
          end
          ST_DATA: begin
            if (bit_cnt == LAST_BIT) begin
              bit_cnt <= '0;
              if (par_en_q) begin
                state  <= ST_PARITY;
                TX_OUT <= par_bit;
              end else begin
                state  <= ST_STOP;
                TX_OUT <= IDLE_LEVEL;
              end
            end else begin
              bit_cnt <= bit_nxt;
              TX_OUT  <= data_q[bit_nxt];
            end
          end
          ST_PARITY: begin
            state  <= ST_STOP;
            TX_OUT <= IDLE_LEVEL;
          end
          ST_STOP: begin
            if (stop2_q && !stop_second) begin
              stop_second <= 1'b1;
            end else begin
              state <= ST_IDLE;
              BUSY  <= 1'b0;
            end
          end
          default: begin
            state  <= ST_IDLE;
            TX_OUT <= IDLE_LEVEL;
            BUSY   <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_framer.sv
// Scoreboard bench for uart_tx_framer: 8-bit and 5-bit instances share clock,
// reset and a divide-by-4 TICK; a line monitor checks every frame against a model.
module tb_uart_tx_framer;

  typedef struct {
    logic [15:0] bits;
    int          len;
  } frame_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic tick = 1'b0;
  logic tick_en = 1'b1;
  logic tx8, busy8, tx5, busy5;
  bit   sel5 = 1'b0;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int tick_div = 0;
  int n_ack8 = 0, n_ack5 = 0, exp_ack8 = 0, exp_ack5 = 0;

  frame_t      sb_q[$];
  frame_t      mon_exp;
  logic [15:0] mon_got;
  int          mon_n;
  bit          mon_active = 1'b0;
  logic        mon_line;

  uart_tx_framer_if #(.DATA_WIDTH(8)) bus8 ();
  uart_tx_framer_if #(.DATA_WIDTH(5)) bus5 ();

  uart_tx_framer #(.DATA_WIDTH(8), .IDLE_LEVEL(1'b1)) dut8 (
    .CLK(clk), .RST(rst), .TICK(tick), .bus(bus8), .TX_OUT(tx8), .BUSY(busy8)
  );
  uart_tx_framer #(.DATA_WIDTH(5), .IDLE_LEVEL(1'b1)) dut5 (
    .CLK(clk), .RST(rst), .TICK(tick), .bus(bus5), .TX_OUT(tx5), .BUSY(busy5)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic frame_t build_frame(input logic [8:0] data, input int width,
                                         input logic pe, input logic pt, input logic s2);
    frame_t f;
    logic   p;
    f.bits    = '1;
    f.bits[0] = 1'b0;
    p         = pt;
    for (int i = 0; i < width; i++) begin
      f.bits[1+i] = data[i];
      p           = p ^ data[i];
    end
    f.len = 1 + width;
    if (pe) begin
      f.bits[f.len] = p;
      f.len++;
    end
    f.len += s2 ? 2 : 1;
    return f;
  endfunction

  // TICK updates 2 ns after each rising edge so it is stable at the next one.
  initial begin
    forever begin
      @(posedge clk);
      #2;
      tick     = tick_en && (tick_div == 3);
      tick_div = (tick_div + 1) % 4;
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (bus8.DATA_ACK) n_ack8++;
      if (bus5.DATA_ACK) n_ack5++;
    end
  end

  // Line monitor: a low line on a tick opens a frame, every later tick adds one bit.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      mon_line = sel5 ? tx5 : tx8;
      if (rst) begin
        mon_active = 1'b0;
      end else if (tick) begin
        if (!mon_active) begin
          if (mon_line == 1'b0) begin
            if (sb_q.size() == 0) begin
              check("unexpected_start", 1, 0);
            end else begin
              mon_exp    = sb_q.pop_front();
              mon_got    = '1;
              mon_got[0] = 1'b0;
              mon_n      = 1;
              mon_active = 1'b1;
            end
          end
        end else begin
          mon_got[mon_n] = mon_line;
          mon_n++;
          if (mon_n == mon_exp.len) begin
            check("frame_bits", {16'h0, mon_got}, {16'h0, mon_exp.bits});
            mon_active = 1'b0;
          end
        end
      end
    end
  end

  task automatic send(input bit to5, input logic [8:0] data, input logic pe, input logic pt,
                      input logic s2, input bit hold, output int ack_cyc);
    @(negedge clk);
    if (to5) begin
      bus5.P_DATA = data[4:0]; bus5.PAR_EN = pe; bus5.PAR_TYP = pt; bus5.STOP_2 = s2;
      bus5.DATA_VALID = 1'b1;
      exp_ack5++;
    end else begin
      bus8.P_DATA = data[7:0]; bus8.PAR_EN = pe; bus8.PAR_TYP = pt; bus8.STOP_2 = s2;
      bus8.DATA_VALID = 1'b1;
      exp_ack8++;
    end
    sb_q.push_back(build_frame(data, to5 ? 5 : 8, pe, pt, s2));
    ack_cyc = -1;
    for (int i = 0; i < 400; i++) begin
      @(posedge clk);
      #1;
      if (to5 ? bus5.DATA_ACK : bus8.DATA_ACK) begin
        ack_cyc = cyc;
        break;
      end
    end
    if (ack_cyc < 0) begin
      check("ack_timeout", 0, 1);
      return;
    end
    check("busy_on_ack", to5 ? busy5 : busy8, 1);
    @(posedge clk);
    #1;
    check("ack_one_cycle", to5 ? bus5.DATA_ACK : bus8.DATA_ACK, 0);
    @(negedge clk);
    if (!hold) begin
      // Scramble inputs mid-frame; the frame in flight must not change.
      if (to5) begin
        bus5.DATA_VALID = 1'b0; bus5.P_DATA = 5'($urandom);
        bus5.PAR_EN = 1'($urandom); bus5.PAR_TYP = 1'($urandom); bus5.STOP_2 = 1'($urandom);
      end else begin
        bus8.DATA_VALID = 1'b0; bus8.P_DATA = 8'($urandom);
        bus8.PAR_EN = 1'($urandom); bus8.PAR_TYP = 1'($urandom); bus8.STOP_2 = 1'($urandom);
      end
    end
  endtask

  task automatic wait_idle(input bit to5, input int ack_cyc, input int exp_cycles, input string tag);
    for (int i = 0; i < 400; i++) begin
      @(posedge clk);
      #1;
      if (!(to5 ? busy5 : busy8)) begin
        check(tag, cyc - ack_cyc, exp_cycles);
        check({tag, "_line_idle"}, to5 ? tx5 : tx8, 1);
        return;
      end
    end
    check({tag, "_timeout"}, 0, 1);
  endtask

  task automatic wait_ticks(input int n);
    int seen = 0;
    for (int i = 0; i < 200 && seen < n; i++) begin
      @(posedge clk);
      #1;
      if (tick) seen++;
    end
    check("tick_wait", seen, n);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int t1, t2;
    bus8.P_DATA = '0; bus8.PAR_EN = 0; bus8.PAR_TYP = 0; bus8.STOP_2 = 0; bus8.DATA_VALID = 1'b1;
    bus5.P_DATA = '0; bus5.PAR_EN = 0; bus5.PAR_TYP = 0; bus5.STOP_2 = 0; bus5.DATA_VALID = 1'b0;

    // Reset with ticks running and a pending request: nothing may be accepted.
    for (int i = 0; i < 8; i++) begin
      @(posedge clk);
      #1;
      check("rst_ack", bus8.DATA_ACK, 0);
    end
    check("rst_tx8", tx8, 1);
    check("rst_busy8", busy8, 0);
    check("rst_tx5", tx5, 1);
    check("rst_busy5", busy5, 0);
    @(negedge clk);
    bus8.DATA_VALID = 1'b0;
    rst = 1'b0;

    // Basic frame, then even/odd parity, then parity with two stop bits.
    send(0, 9'h0A5, 0, 0, 0, 0, t1);
    wait_idle(0, t1, 40, "busy_a5");
    send(0, 9'h003, 1, 0, 0, 0, t1);
    wait_idle(0, t1, 44, "busy_par_even");
    send(0, 9'h003, 1, 1, 0, 0, t1);
    wait_idle(0, t1, 44, "busy_par_odd");
    send(0, 9'h003, 1, 1, 1, 0, t1);
    wait_idle(0, t1, 48, "busy_stop2");

    // Back-to-back: valid held, second start directly after the stop bit.
    send(0, 9'h055, 0, 0, 0, 1, t1);
    send(0, 9'h0F0, 0, 0, 0, 0, t2);
    check("b2b_ack_spacing", t2 - t1, 40);
    wait_idle(0, t2, 40, "busy_b2b");

    // Reset during data bit 3 (a 0 bit), with a request pending through reset.
    send(0, 9'h035, 1, 0, 0, 0, t1);
    wait_ticks(4);
    check("pre_rst_bit3", tx8, 0);
    @(negedge clk);
    rst = 1'b1;
    bus8.DATA_VALID = 1'b1;
    @(posedge clk);
    #1;
    check("mid_rst_tx", tx8, 1);
    check("mid_rst_busy", busy8, 0);
    for (int i = 0; i < 9; i++) begin
      @(posedge clk);
      #1;
      check("mid_rst_no_ack", bus8.DATA_ACK, 0);
    end
    @(negedge clk);
    rst = 1'b0;
    bus8.DATA_VALID = 1'b0;
    send(0, 9'h0C3, 1, 1, 1, 0, t1);
    wait_idle(0, t1, 48, "busy_after_rst");

    // Five-bit instance: odd parity on 1F, then even parity with two stops.
    sel5 = 1'b1;
    send(1, 9'h01F, 1, 1, 0, 0, t1);
    wait_idle(1, t1, 32, "busy_w5_1f");
    send(1, 9'h00A, 1, 0, 1, 0, t1);
    wait_idle(1, t1, 36, "busy_w5_0a");
    sel5 = 1'b0;

    // TICK held low with a request pending: no acceptance, line stays idle.
    @(negedge clk);
    tick_en = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    bus8.DATA_VALID = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      check("notick_ack", bus8.DATA_ACK, 0);
      check("notick_tx", tx8, 1);
    end
    @(negedge clk);
    bus8.DATA_VALID = 1'b0;
    tick_en = 1'b1;
    repeat (8) @(posedge clk);

    check("ack_count8", n_ack8, exp_ack8);
    check("ack_count5", n_ack5, exp_ack5);
    check("scoreboard_empty", sb_q.size(), 0);
    check("monitor_idle", mon_active, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
